// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: 640x480@60 defaults, counter widths and the
// helpers that derive line/frame totals and sync pulse boundaries.
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int HOLD_W  = 6;
  localparam int FRAME_W = 2;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_ANIM_HOLD = 11;

  function automatic int span_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  // Sync pulse occupies [first, last] inclusive, right after the front porch.
  function automatic int sync_first(input int display, input int front);
    return display + front;
  endfunction

  function automatic int sync_last(input int display, input int front, input int sync);
    return display + front + sync - 1;
  endfunction

  localparam int DEF_H_TOTAL      = span_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL      = span_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
  localparam int DEF_H_SYNC_FIRST = sync_first(DEF_H_DISPLAY, DEF_H_FRONT);
  localparam int DEF_H_SYNC_LAST  = sync_last(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC);
  localparam int DEF_V_SYNC_FIRST = sync_first(DEF_V_DISPLAY, DEF_V_FRONT);
  localparam int DEF_V_SYNC_LAST  = sync_last(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC);

endpackage

// File: rtl/vga_timing_gen_anim_sequencer.sv
// Animation frame sequencer: holds each of four frames for ANIM_HOLD
// vertical blanks, advancing only on unpaused vblank_start cycles.
module anim_sequencer
  import vga_timing_pkg::*;
#(
  parameter int ANIM_HOLD = DEF_ANIM_HOLD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vblank_start,
  input  logic               anim_pause,
  output logic [FRAME_W-1:0] anim_frame
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ANIM_HOLD - 1);

  logic [HOLD_W-1:0]  r_hold;
  logic [FRAME_W-1:0] r_frame;
  logic               w_event;
  logic               w_wrap;

  assign w_event = vblank_start && !anim_pause;
  assign w_wrap  = (r_hold == HOLD_LAST);

  // vblank_start is a one-cycle strobe, so the frame only ever moves on the
  // edge leaving line 0 of vertical blank, never inside the visible area.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold  <= '0;
      r_frame <= '0;
    end else if (w_event) begin
      if (w_wrap) begin
        r_hold  <= '0;
        r_frame <= r_frame + FRAME_W'(1);
      end else begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end
  end

  assign anim_frame = r_frame;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, registered sync/blank/strobe decodes
// aligned with the counters, and the animation frame sequencer.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int ANIM_HOLD = DEF_ANIM_HOLD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               anim_pause,
  output logic [CNT_W-1:0]   hpos,
  output logic [CNT_W-1:0]   vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank_start,
  output logic [FRAME_W-1:0] anim_frame
);

  localparam int H_TOTAL = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] H_SS     = CNT_W'(sync_first(H_DISPLAY, H_FRONT));
  localparam logic [CNT_W-1:0] H_SE     = CNT_W'(sync_last(H_DISPLAY, H_FRONT, H_SYNC));
  localparam logic [CNT_W-1:0] V_SS     = CNT_W'(sync_first(V_DISPLAY, V_FRONT));
  localparam logic [CNT_W-1:0] V_SE     = CNT_W'(sync_last(V_DISPLAY, V_FRONT, V_SYNC));

  logic [CNT_W-1:0] r_hpos;
  logic [CNT_W-1:0] r_vpos;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_display_on;
  logic             r_line_start;
  logic             r_frame_start;
  logic             r_vblank_start;

  logic [CNT_W-1:0] w_hpos_nxt;
  logic [CNT_W-1:0] w_vpos_nxt;
  logic [CNT_W-1:0] w_dec_h;
  logic [CNT_W-1:0] w_dec_v;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_display_on;
  logic             w_line_start;
  logic             w_frame_start;
  logic             w_vblank_start;

  always_comb begin
    w_hpos_nxt = r_hpos + CNT_W'(1);
    w_vpos_nxt = r_vpos;
    if (r_hpos == H_LAST) begin
      w_hpos_nxt = '0;
      w_vpos_nxt = (r_vpos == V_LAST) ? '0 : r_vpos + CNT_W'(1);
    end
  end

  // Decode the position the counters will hold after this edge, so the
  // registered flags line up with hpos/vpos without any output logic.
  assign w_dec_h = reset ? '0 : w_hpos_nxt;
  assign w_dec_v = reset ? '0 : w_vpos_nxt;

  always_comb begin
    w_hsync        = !((w_dec_h >= H_SS) && (w_dec_h <= H_SE));
    w_vsync        = !((w_dec_v >= V_SS) && (w_dec_v <= V_SE));
    w_display_on   = (w_dec_h < H_VIS) && (w_dec_v < V_VIS);
    w_line_start   = (w_dec_h == '0);
    w_frame_start  = (w_dec_h == '0) && (w_dec_v == '0);
    w_vblank_start = (w_dec_h == '0) && (w_dec_v == V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else begin
      r_hpos <= w_hpos_nxt;
      r_vpos <= w_vpos_nxt;
    end
    r_hsync        <= w_hsync;
    r_vsync        <= w_vsync;
    r_display_on   <= w_display_on;
    r_line_start   <= w_line_start;
    r_frame_start  <= w_frame_start;
    r_vblank_start <= w_vblank_start;
  end

  anim_sequencer #(
    .ANIM_HOLD (ANIM_HOLD)
  ) u_anim (
    .clk          (clk),
    .reset        (reset),
    .vblank_start (r_vblank_start),
    .anim_pause   (anim_pause),
    .anim_frame   (anim_frame)
  );

  assign hpos         = r_hpos;
  assign vpos         = r_vpos;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign display_on   = r_display_on;
  assign line_start   = r_line_start;
  assign frame_start  = r_frame_start;
  assign vblank_start = r_vblank_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a shrunken-timing
// instance run side by side against a per-cycle reference raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic anim_pause;

  always #5 clk = ~clk;

  logic [9:0] d_hpos[2];
  logic [9:0] d_vpos[2];
  logic       d_hsync[2];
  logic       d_vsync[2];
  logic       d_display_on[2];
  logic       d_line_start[2];
  logic       d_frame_start[2];
  logic       d_vblank_start[2];
  logic [1:0] d_anim_frame[2];

  // index 0: default 800x525 timing, index 1: 30x17 timing (510-cycle frame)
  int p_hd[2]   = '{640, 16};
  int p_hf[2]   = '{16, 4};
  int p_hs[2]   = '{96, 6};
  int p_hb[2]   = '{48, 4};
  int p_vd[2]   = '{480, 10};
  int p_vf[2]   = '{10, 2};
  int p_vs[2]   = '{2, 2};
  int p_vb[2]   = '{33, 3};
  int p_hold[2] = '{11, 11};

  localparam int SMALL_FRAME = 510;

  vga_timing_gen dut_def (
    .clk          (clk),
    .reset        (reset),
    .anim_pause   (anim_pause),
    .hpos         (d_hpos[0]),
    .vpos         (d_vpos[0]),
    .hsync        (d_hsync[0]),
    .vsync        (d_vsync[0]),
    .display_on   (d_display_on[0]),
    .line_start   (d_line_start[0]),
    .frame_start  (d_frame_start[0]),
    .vblank_start (d_vblank_start[0]),
    .anim_frame   (d_anim_frame[0])
  );

  vga_timing_gen #(
    .H_DISPLAY (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (4),
    .V_DISPLAY (10), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .ANIM_HOLD (11)
  ) dut_small (
    .clk          (clk),
    .reset        (reset),
    .anim_pause   (anim_pause),
    .hpos         (d_hpos[1]),
    .vpos         (d_vpos[1]),
    .hsync        (d_hsync[1]),
    .vsync        (d_vsync[1]),
    .display_on   (d_display_on[1]),
    .line_start   (d_line_start[1]),
    .frame_start  (d_frame_start[1]),
    .vblank_start (d_vblank_start[1]),
    .anim_frame   (d_anim_frame[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int m_h[2]    = '{0, 0};
  int m_v[2]    = '{0, 0};
  int m_hold[2] = '{0, 0};
  int m_af[2]   = '{0, 0};

  logic [27:0] exp_q0[$];
  logic [27:0] exp_q1[$];

  // ---------------- reference model ----------------
  task automatic model_edge(input int k);
    logic vb;
    int   htot;
    int   vtot;
    htot = p_hd[k] + p_hf[k] + p_hs[k] + p_hb[k];
    vtot = p_vd[k] + p_vf[k] + p_vs[k] + p_vb[k];
    vb   = (m_h[k] == 0) && (m_v[k] == p_vd[k]);
    if (reset) begin
      m_h[k] = 0; m_v[k] = 0; m_hold[k] = 0; m_af[k] = 0;
    end else begin
      if (vb && !anim_pause) begin
        if (m_hold[k] == p_hold[k] - 1) begin
          m_hold[k] = 0;
          m_af[k]   = (m_af[k] + 1) % 4;
        end else begin
          m_hold[k] = m_hold[k] + 1;
        end
      end
      m_h[k] = m_h[k] + 1;
      if (m_h[k] == htot) begin
        m_h[k] = 0;
        m_v[k] = (m_v[k] + 1 == vtot) ? 0 : m_v[k] + 1;
      end
    end
  endtask

  function automatic logic [27:0] model_vec(input int k);
    int         h;
    int         v;
    logic       hs_n, vs_n, don, ls, fs, vbs;
    logic [9:0] hv, vv;
    logic [1:0] af;
    h    = m_h[k];
    v    = m_v[k];
    hs_n = !((h >= p_hd[k] + p_hf[k]) && (h < p_hd[k] + p_hf[k] + p_hs[k]));
    vs_n = !((v >= p_vd[k] + p_vf[k]) && (v < p_vd[k] + p_vf[k] + p_vs[k]));
    don  = (h < p_hd[k]) && (v < p_vd[k]);
    ls   = (h == 0);
    fs   = (h == 0) && (v == 0);
    vbs  = (h == 0) && (v == p_vd[k]);
    hv   = 10'(h);
    vv   = 10'(v);
    af   = 2'(m_af[k]);
    return {hv, vv, hs_n, vs_n, don, ls, fs, vbs, af};
  endfunction

  function automatic logic [27:0] obs_vec(input int k);
    return {d_hpos[k], d_vpos[k], d_hsync[k], d_vsync[k], d_display_on[k],
            d_line_start[k], d_frame_start[k], d_vblank_start[k], d_anim_frame[k]};
  endfunction

  // One clock: advance the model, queue expectations, then check both DUTs.
  task automatic step();
    logic [27:0] e;
    logic [27:0] o;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    exp_q0.push_back(model_vec(0));
    exp_q1.push_back(model_vec(1));
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      o = obs_vec(k);
      if (bad < 40) begin
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL scoreboard dut%0d cyc=%0d got h=%0d v=%0d flags=%b af=%0d want h=%0d v=%0d flags=%b af=%0d",
                   k, cyc, o[27:18], o[17:8], o[7:2], o[1:0], e[27:18], e[17:8], e[7:2], e[1:0]);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset      = 1'b1;
    anim_pause = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({d_hpos[k], d_vpos[k], d_anim_frame[k]} !== 22'd0) begin
        bad++;
        $display("FAIL reset_pos dut%0d got h=%0d v=%0d af=%0d want 0/0/0", k, d_hpos[k], d_vpos[k], d_anim_frame[k]);
      end
      total++;
      if ({d_hsync[k], d_vsync[k], d_display_on[k], d_line_start[k], d_frame_start[k], d_vblank_start[k]} !== 6'b111110) begin
        bad++;
        $display("FAIL reset_flags dut%0d got %b want 111110", k,
                 {d_hsync[k], d_vsync[k], d_display_on[k], d_line_start[k], d_frame_start[k], d_vblank_start[k]});
      end
    end
    reset      = 1'b0;
    anim_pause = 1'b0;
  endtask

  task automatic test_line();
    int ls_cnt, ls_misplaced, don_cnt, lo_cnt, runs, first_lo;
    logic prev_hs;
    ls_cnt = 0; ls_misplaced = 0;
    for (int i = 0; i <= 800; i++) begin
      if (i > 0) step();
      if (d_line_start[0]) begin
        ls_cnt++;
        if (i != 0 && i != 800) ls_misplaced++;
      end
      if (i == 1) begin
        total++;
        if (d_hpos[0] !== 10'd1 || d_vpos[0] !== 10'd0) begin
          bad++;
          $display("FAIL first_count got h=%0d v=%0d want h=1 v=0", d_hpos[0], d_vpos[0]);
        end
      end
    end
    total++;
    if (ls_cnt != 2 || ls_misplaced != 0) begin
      bad++;
      $display("FAIL line_start_count got %0d (misplaced %0d) want 2 (0)", ls_cnt, ls_misplaced);
    end
    total++;
    if (d_hpos[0] !== 10'd0 || d_vpos[0] !== 10'd1) begin
      bad++;
      $display("FAIL line_wrap got h=%0d v=%0d want h=0 v=1", d_hpos[0], d_vpos[0]);
    end
    don_cnt = 0; lo_cnt = 0; runs = 0; first_lo = -1; prev_hs = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) step();
      if (d_display_on[0]) don_cnt++;
      if (!d_hsync[0]) begin
        lo_cnt++;
        if (prev_hs) begin
          runs++;
          if (first_lo < 0) first_lo = int'(d_hpos[0]);
        end
      end
      prev_hs = d_hsync[0];
    end
    total++;
    if (lo_cnt != 96 || runs != 1 || first_lo != 656) begin
      bad++;
      $display("FAIL hsync_pulse got len=%0d runs=%0d start=%0d want 96/1/656", lo_cnt, runs, first_lo);
    end
    total++;
    if (don_cnt != 640) begin
      bad++;
      $display("FAIL display_on_line got %0d want 640", don_cnt);
    end
  endtask

  task automatic test_frame();
    int found, vs_lo, fvs_v, fvs_h, vb_cnt, vb_v, vb_h, fs_extra;
    found = 0;
    for (int i = 0; i < 2 * SMALL_FRAME && found == 0; i++) begin
      if (d_frame_start[1]) found = 1;
      else step();
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL frame_start_wait got none want a frame_start within %0d cycles", 2 * SMALL_FRAME);
    end
    vs_lo = 0; fvs_v = -1; fvs_h = -1; vb_cnt = 0; vb_v = -1; vb_h = -1; fs_extra = 0;
    for (int i = 0; i < SMALL_FRAME; i++) begin
      if (i > 0) begin
        step();
        if (d_frame_start[1]) fs_extra++;
      end
      if (!d_vsync[1]) begin
        vs_lo++;
        if (fvs_v < 0) begin fvs_v = int'(d_vpos[1]); fvs_h = int'(d_hpos[1]); end
      end
      if (d_vblank_start[1]) begin
        vb_cnt++; vb_v = int'(d_vpos[1]); vb_h = int'(d_hpos[1]);
      end
    end
    step();
    total++;
    if (d_frame_start[1] !== 1'b1 || fs_extra != 0) begin
      bad++;
      $display("FAIL frame_period got fs=%b extra=%0d want fs=1 extra=0 at %0d cycles", d_frame_start[1], fs_extra, SMALL_FRAME);
    end
    total++;
    if (vs_lo != 60 || fvs_v != 12 || fvs_h != 0) begin
      bad++;
      $display("FAIL vsync_pulse got len=%0d at v=%0d h=%0d want 60 at v=12 h=0", vs_lo, fvs_v, fvs_h);
    end
    total++;
    if (vb_cnt != 1 || vb_v != 10 || vb_h != 0) begin
      bad++;
      $display("FAIL vblank_start got cnt=%0d at v=%0d h=%0d want 1 at v=10 h=0", vb_cnt, vb_v, vb_h);
    end
  endtask

  task automatic test_anim();
    int vb_seen, changes;
    logic prev_vb, prev_don;
    logic [1:0] prev_af;
    reset = 1'b1; step(); reset = 1'b0;
    vb_seen = 0; changes = 0; prev_af = d_anim_frame[1];
    for (int i = 0; i < 44 * SMALL_FRAME + 20; i++) begin
      prev_vb  = d_vblank_start[1];
      prev_don = d_display_on[1];
      if (prev_vb) vb_seen++;
      step();
      if (d_anim_frame[1] !== prev_af) begin
        changes++;
        total++;
        if (!(prev_vb && !prev_don && vb_seen == 11 * changes && d_anim_frame[1] == 2'(changes))) begin
          bad++;
          $display("FAIL anim_step got af=%0d after vb=%0d (vb_cyc=%b disp=%b) want af=%0d after vb=%0d in blank",
                   d_anim_frame[1], vb_seen, prev_vb, prev_don, 2'(changes), 11 * changes);
        end
        prev_af = d_anim_frame[1];
      end
    end
    total++;
    if (changes != 4 || vb_seen != 44 || d_anim_frame[1] !== 2'd0) begin
      bad++;
      $display("FAIL anim_wrap got changes=%0d vb=%0d af=%0d want 4/44/0", changes, vb_seen, d_anim_frame[1]);
    end
  endtask

  task automatic test_pause();
    int vb_seen, changed_at;
    logic prev_vb;
    reset = 1'b1; step(); reset = 1'b0;
    vb_seen = 0; changed_at = -1;
    for (int i = 0; i < 17 * SMALL_FRAME && changed_at < 0; i++) begin
      prev_vb = d_vblank_start[1];
      if (prev_vb) vb_seen++;
      step();
      if (d_anim_frame[1] !== 2'd0) changed_at = vb_seen;
      if (prev_vb && vb_seen == 5)  anim_pause = 1'b1;
      if (prev_vb && vb_seen == 10) anim_pause = 1'b0;
    end
    anim_pause = 1'b0;
    total++;
    if (changed_at != 16 || d_anim_frame[1] !== 2'd1) begin
      bad++;
      $display("FAIL pause_delay got change at vb=%0d af=%0d want vb=16 af=1", changed_at, d_anim_frame[1]);
    end
  endtask

  task automatic test_reset_mid();
    int found;
    found = 0;
    for (int i = 0; i < 12 * SMALL_FRAME && found == 0; i++) begin
      if (d_anim_frame[1] == 2'd2) found = 1;
      else step();
    end
    for (int i = 0; i < 2 * SMALL_FRAME && found == 1; i++) begin
      if (d_hpos[1] == 10'd7 && d_vpos[1] == 10'd5) found = 2;
      else step();
    end
    total++;
    if (found != 2) begin
      bad++;
      $display("FAIL reset_mid_setup got stage=%0d want 2 (af=2 then h=7 v=5)", found);
    end
    reset = 1'b1; anim_pause = 1'b1;
    step();
    reset = 1'b0; anim_pause = 1'b0;
    total++;
    if (d_hpos[1] !== 10'd0 || d_vpos[1] !== 10'd0 || d_anim_frame[1] !== 2'd0 || d_frame_start[1] !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid got h=%0d v=%0d af=%0d fs=%b want 0/0/0/1", d_hpos[1], d_vpos[1], d_anim_frame[1], d_frame_start[1]);
    end
    step();
    total++;
    if (d_hpos[1] !== 10'd1 || d_vpos[1] !== 10'd0 || d_hpos[0] !== 10'd1) begin
      bad++;
      $display("FAIL reset_mid_resume got h=%0d v=%0d (def h=%0d) want h=1 v=0 (def h=1)", d_hpos[1], d_vpos[1], d_hpos[0]);
    end
  endtask

  initial begin
    reset      = 1'b1;
    anim_pause = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_anim();
    test_pause();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16; H_SYNC, default 96; H_BACK, default 48 (H_TOTAL = 800).
REQ-003 The block SHALL have parameter V_DISPLAY, default 480; V_FRONT, default 10; V_SYNC, default 2; V_BACK, default 33 (V_TOTAL = 525).
REQ-004 The block SHALL have parameter ANIM_HOLD, default 11, frames each animation frame is held (legal range 1..63).
REQ-005 The block SHALL have port clk, input, 1 bit, single pixel clock; every register in the block uses it.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-007 The block SHALL have port anim_pause, input, 1 bit; high freezes animation state.
REQ-008 The block SHALL have ports hpos and vpos, output, 10 bits each, current pixel column and row.
REQ-009 The block SHALL have ports hsync and vsync, output, 1 bit each, active-low sync pulses.
REQ-010 The block SHALL have port display_on, output, 1 bit, high inside the visible area.
REQ-011 The block SHALL have ports line_start, frame_start and vblank_start, output, 1 bit each, single-cycle strobes.
REQ-012 The block SHALL have port anim_frame, output, 2 bits, animation frame select for the frame LUT mux.

Function
REQ-013 hpos SHALL increment by 1 per clock and wrap from H_TOTAL-1 (799) to 0.
REQ-014 vpos SHALL increment only in the cycle hpos wraps; it SHALL wrap from V_TOTAL-1 (524) to 0 on that same edge.
REQ-015 display_on SHALL be 1 iff hpos < 640 and vpos < 480.
REQ-016 hsync SHALL be 0 iff 656 <= hpos <= 751; vsync SHALL be 0 iff 490 <= vpos <= 491.
REQ-017 line_start SHALL be 1 iff hpos == 0; frame_start SHALL be 1 iff hpos == 0 and vpos == 0.
REQ-018 vblank_start SHALL be 1 iff hpos == 0 and vpos == 480.
REQ-019 hsync, vsync, display_on and all strobes SHALL be registered outputs decoded from next-state counters, so each is valid in the same cycle as the hpos/vpos it describes (zero relative latency, no combinational path from counters to outputs).
REQ-020 An internal hold counter (6 bits) SHALL advance only on a vblank_start cycle with anim_pause == 0.
REQ-021 When the hold counter equals ANIM_HOLD-1 at such an event, it SHALL clear to 0 and anim_frame SHALL increment, wrapping 3 -> 0; otherwise the hold counter SHALL increment.
REQ-022 anim_frame SHALL change only on the edge ending a vblank_start cycle, so it is constant throughout every visible region.
REQ-023 If anim_pause is high during vblank_start, hold counter and anim_frame SHALL both be unchanged; deasserting pause SHALL resume counting from the held values.
REQ-024 ANIM_HOLD == 1 SHALL advance anim_frame on every vblank_start.

Reset
REQ-025 While reset is high at a clock edge: hpos=0, vpos=0, hold counter=0, anim_frame=0.
REQ-026 Registered decodes SHALL take the values corresponding to (0,0): display_on=1, hsync=1, vsync=1, line_start=1, frame_start=1, vblank_start=0.
REQ-027 Reset asserted mid-frame SHALL take effect on the next edge regardless of counter state; the first edge with reset low SHALL produce hpos=1, vpos=0.
REQ-028 reset SHALL have priority over anim_pause and all counting.

Structure
REQ-029 Timing constants (defaults and derived H_TOTAL, V_TOTAL, sync start/end) SHALL live in shared package vga_timing_pkg.
REQ-030 The hold counter and anim_frame logic SHALL be one sub-module, anim_sequencer, clocked by clk, with inputs reset, vblank_start and anim_pause, and output anim_frame.

Verification
REQ-031 Release reset, run 800 cycles -> hpos back to 0, vpos = 1, line_start high at cycles 0 and 800 only.
REQ-032 One line -> hsync low for exactly 96 consecutive cycles starting at hpos 656; display_on high for exactly 640 cycles.
REQ-033 One full frame -> frame_start period 420000 cycles; vsync low for 1600 cycles beginning at vpos 490, hpos 0; vblank_start once, at vpos 480.
REQ-034 ANIM_HOLD=11, pause low -> anim_frame 0->1 after the 11th vblank_start, wraps to 0 after the 44th; never changes while display_on is 1.
REQ-035 Hold anim_pause high across 5 vblank_starts mid-count -> anim_frame and hold count unchanged; the next transition is delayed by exactly 5 frames.
REQ-036 Assert reset for 1 cycle at hpos=300, vpos=200 with anim_frame=2 -> next cycle hpos=0, vpos=0, anim_frame=0, frame_start=1; the following cycle hpos=1.
